// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller.
// Contents: FSM state encoding, direction codes driven on direccion, and the
// floor-index width helper used by the interface and the controller.
package elevator_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StMoving   = 2'd1,
    StDoorOpen = 2'd2
  } state_e;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  // Floor index width; never narrower than one bit.
  function automatic int unsigned floor_w(input int unsigned num_floors);
    return (num_floors > 1) ? $clog2(num_floors) : 1;
  endfunction

endpackage

// File: rtl/elevator_if.sv
// Bundle between the building (call buttons, displays) and the controller.
// Signals: llamadas (per-floor calls in), piso, direccion, puertas_abiertas,
// llegada, pendientes (status out). With DOOR_HOLD_EN defined, boton_abrir
// (door-hold button) is added as an input to the controller.
// Modports: master = building side, slave = controller side.
interface elevator_if
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 4
);
  localparam int unsigned FLOOR_W = floor_w(NUM_FLOORS);

  logic [NUM_FLOORS-1:0] llamadas;
  logic [FLOOR_W-1:0]    piso;
  logic [1:0]            direccion;
  logic                  puertas_abiertas;
  logic                  llegada;
  logic [NUM_FLOORS-1:0] pendientes;
`ifdef DOOR_HOLD_EN
  logic                  boton_abrir;
`endif

  modport master (
    output llamadas,
`ifdef DOOR_HOLD_EN
    output boton_abrir,
`endif
    input  piso,
    input  direccion,
    input  puertas_abiertas,
    input  llegada,
    input  pendientes
  );

  modport slave (
    input  llamadas,
`ifdef DOOR_HOLD_EN
    input  boton_abrir,
`endif
    output piso,
    output direccion,
    output puertas_abiertas,
    output llegada,
    output pendientes
  );

endinterface

// File: rtl/elevator_req_scan.sv
// Combinational scan of the outstanding-call vector relative to the cab.
// Ports: pend_i (latched calls), piso_i (current floor);
//        here_o (call at piso), above_o (any call above), below_o (any below).
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = 4,
  localparam int unsigned FLOOR_W = floor_w(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pend_i,
  input  logic [FLOOR_W-1:0]    piso_i,
  output logic                  here_o,
  output logic                  above_o,
  output logic                  below_o
);

  // Loop compare instead of pend_i[piso_i] so non-power-of-two floor counts
  // never index past the vector.
  always_comb begin
    here_o  = 1'b0;
    above_o = 1'b0;
    below_o = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == piso_i) here_o  = here_o  | pend_i[i];
      if (FLOOR_W'(i) >  piso_i) above_o = above_o | pend_i[i];
      if (FLOOR_W'(i) <  piso_i) below_o = below_o | pend_i[i];
    end
  end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN-order elevator controller for NUM_FLOORS floors.
// Ports: clk, rst_n (synchronous, active low), bus (elevator_if.slave):
//   llamadas in, piso / direccion / puertas_abiertas / llegada / pendientes out.
// Optional: define DOOR_HOLD_EN to add bus.boton_abrir, which holds the doors
// open during the dwell and opens them from idle without a call.
module elevator_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS    = 4,
  parameter int unsigned TRAVEL_CYCLES = 50000000,
  parameter int unsigned DOOR_CYCLES   = 100000000,
  parameter int unsigned RESET_FLOOR   = 0
) (
  input logic       clk,
  input logic       rst_n,
  elevator_if.slave bus
);

  localparam int unsigned FLOOR_W = floor_w(NUM_FLOORS);
  localparam int unsigned MaxCyc  = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int unsigned CntW    = $clog2(MaxCyc);
  localparam logic [CntW-1:0] TravelLast = CntW'(TRAVEL_CYCLES - 1);
  localparam logic [CntW-1:0] DoorLast   = CntW'(DOOR_CYCLES - 1);

  state_e                state_q, state_d;
  logic [FLOOR_W-1:0]    piso_q, piso_d;
  logic [1:0]            dir_q, dir_d;
  logic                  doors_q, doors_d;
  logic                  llegada_q, llegada_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d;
  logic [CntW-1:0]       timer_q, timer_d;

  logic                  here, above, below;
  logic                  hold;
  logic [FLOOR_W-1:0]    piso_step;
  logic                  step_call;
  logic                  ahead, behind;
  logic [1:0]            dir_fwd, dir_rev;
  logic                  clr_en;
  logic [FLOOR_W-1:0]    clr_floor;

`ifdef DOOR_HOLD_EN
  assign hold = bus.boton_abrir;
`else
  assign hold = 1'b0;
`endif

  elevator_req_scan #(
    .NUM_FLOORS(NUM_FLOORS)
  ) u_scan (
    .pend_i (pend_q),
    .piso_i (piso_q),
    .here_o (here),
    .above_o(above),
    .below_o(below)
  );

  // Direction-relative view; DIR_NONE falls back to the idle preference (up).
  always_comb begin
    if (dir_q == DIR_DOWN) begin
      ahead   = below;
      behind  = above;
      dir_fwd = DIR_DOWN;
      dir_rev = DIR_UP;
    end else begin
      ahead   = above;
      behind  = below;
      dir_fwd = DIR_UP;
      dir_rev = DIR_DOWN;
    end
  end

  // Floor reached at the end of the current hop and whether it has a call.
  always_comb begin
    piso_step = (dir_q == DIR_DOWN) ? piso_q - FLOOR_W'(1) : piso_q + FLOOR_W'(1);
    step_call = 1'b0;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      if (FLOOR_W'(i) == piso_step) step_call = pend_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    piso_d    = piso_q;
    dir_d     = dir_q;
    doors_d   = doors_q;
    llegada_d = 1'b0;
    timer_d   = timer_q;
    clr_en    = 1'b0;
    clr_floor = piso_q;

    unique case (state_q)
      StIdle: begin
        if (here || hold) begin
          state_d = StDoorOpen;
          doors_d = 1'b1;
          timer_d = '0;
          clr_en  = here;
        end else if (above) begin
          state_d = StMoving;
          dir_d   = DIR_UP;
          timer_d = '0;
        end else if (below) begin
          state_d = StMoving;
          dir_d   = DIR_DOWN;
          timer_d = '0;
        end else begin
          dir_d = DIR_NONE;
        end
      end

      StMoving: begin
        if (timer_q == TravelLast) begin
          piso_d    = piso_step;
          llegada_d = 1'b1;
          timer_d   = '0;
          if (step_call) begin
            state_d   = StDoorOpen;
            doors_d   = 1'b1;
            clr_en    = 1'b1;
            clr_floor = piso_step;
          end
        end else begin
          timer_d = timer_q + CntW'(1);
        end
      end

      StDoorOpen: begin
        if (here) begin
          // Late call for this floor: absorb it and restart the dwell.
          timer_d = '0;
          clr_en  = 1'b1;
        end else if (hold) begin
          timer_d = '0;
        end else if (timer_q == DoorLast) begin
          doors_d = 1'b0;
          timer_d = '0;
          if (ahead) begin
            state_d = StMoving;
            dir_d   = dir_fwd;
          end else if (behind) begin
            state_d = StMoving;
            dir_d   = dir_rev;
          end else begin
            state_d = StIdle;
            dir_d   = DIR_NONE;
          end
        end else begin
          timer_d = timer_q + CntW'(1);
        end
      end

      default: begin
        state_d = StIdle;
        dir_d   = DIR_NONE;
        doors_d = 1'b0;
        timer_d = '0;
      end
    endcase

    // Service clear beats a same-cycle set of the same bit.
    pend_d = (pend_q | bus.llamadas)
             & ~(clr_en ? (NUM_FLOORS'(1) << clr_floor) : {NUM_FLOORS{1'b0}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      piso_q    <= FLOOR_W'(RESET_FLOOR);
      dir_q     <= DIR_NONE;
      doors_q   <= 1'b0;
      llegada_q <= 1'b0;
      pend_q    <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      piso_q    <= piso_d;
      dir_q     <= dir_d;
      doors_q   <= doors_d;
      llegada_q <= llegada_d;
      pend_q    <= pend_d;
      timer_q   <= timer_d;
    end
  end

  assign bus.piso             = piso_q;
  assign bus.direccion        = dir_q;
  assign bus.puertas_abiertas = doors_q;
  assign bus.llegada          = llegada_q;
  assign bus.pendientes       = pend_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with NUM_FLOORS=4, TRAVEL_CYCLES=4,
// DOOR_CYCLES=3, RESET_FLOOR=0. A per-cycle vector table covers reset,
// a same-floor call and a full up trip; hand sequences cover reversal,
// the up/down tie, mid-travel reset and (with DOOR_HOLD_EN) the door hold.
module tb_elevator_ctrl;
  import elevator_pkg::*;

  localparam int unsigned NF = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elevator_if #(.NUM_FLOORS(NF)) bus ();

  elevator_ctrl #(
    .NUM_FLOORS   (NF),
    .TRAVEL_CYCLES(4),
    .DOOR_CYCLES  (3),
    .RESET_FLOOR  (0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Output tuple: {piso[1:0], direccion[1:0], puertas, llegada, pendientes[3:0]}
  typedef struct packed {
    logic       rst_n;
    logic [3:0] call;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [9:0] o(input logic [1:0] p, input logic [1:0] d,
                                   input logic dr, input logic ll, input logic [3:0] pe);
    return {p, d, dr, ll, pe};
  endfunction

  function automatic logic [9:0] obs();
    return {bus.piso, bus.direccion, bus.puertas_abiertas, bus.llegada, bus.pendientes};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [3:0] m);
    bus.llamadas = m;
    tick();
    bus.llamadas = '0;
  endtask

  // Step until puertas_abiertas == lvl; n = cycles taken, -1 if never seen.
  task automatic wait_doors(input logic lvl, input int max, output int n);
    logic done;
    done = 1'b0;
    n = -1;
    for (int i = 1; i <= max; i++) begin
      if (!done) begin
        tick();
        if (bus.puertas_abiertas === lvl) begin
          n = i;
          done = 1'b1;
        end
      end
    end
  endtask

  int n;

  initial begin
    bus.llamadas = '0;
`ifdef DOOR_HOLD_EN
    bus.boton_abrir = 1'b0;
`endif

    // Reset and same-floor call.
    tbl.push_back('{1'b0, 4'b0000, o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0000, o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0001, o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0001)});
    for (int i = 0; i < 3; i++)
      tbl.push_back('{1'b1, 4'b0000, o(2'd0, DIR_NONE, 1'b1, 1'b0, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0000, o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0000, o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)});
    // Trip 0 -> 3.
    tbl.push_back('{1'b1, 4'b1000, o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b1000)});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{1'b1, 4'b0000, o(2'd0, DIR_UP, 1'b0, 1'b0, 4'b1000)});
    for (int f = 1; f <= 2; f++) begin
      tbl.push_back('{1'b1, 4'b0000, o(2'(f), DIR_UP, 1'b0, 1'b1, 4'b1000)});
      for (int i = 0; i < 3; i++)
        tbl.push_back('{1'b1, 4'b0000, o(2'(f), DIR_UP, 1'b0, 1'b0, 4'b1000)});
    end
    tbl.push_back('{1'b1, 4'b0000, o(2'd3, DIR_UP, 1'b1, 1'b1, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0000, o(2'd3, DIR_UP, 1'b1, 1'b0, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0000, o(2'd3, DIR_UP, 1'b1, 1'b0, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0000, o(2'd3, DIR_NONE, 1'b0, 1'b0, 4'b0000)});
    tbl.push_back('{1'b1, 4'b0000, o(2'd3, DIR_NONE, 1'b0, 1'b0, 4'b0000)});

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      bus.llamadas = tbl[i].call;
      tick();
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
    end
    bus.llamadas = '0;

    // Floor 3 -> 1 down, then idle at 1.
    pulse(4'b0010);
    chk("down_pend", 32'(obs()), 32'(o(2'd3, DIR_NONE, 1'b0, 1'b0, 4'b0010)));
    wait_doors(1'b1, 30, n);
    chk("down_lat", n, 9);
    chk("down_arr", 32'(obs()), 32'(o(2'd1, DIR_DOWN, 1'b1, 1'b1, 4'b0000)));
    wait_doors(1'b0, 10, n);
    chk("down_close", n, 3);
    chk("down_idle", 32'(obs()), 32'(o(2'd1, DIR_NONE, 1'b0, 1'b0, 4'b0000)));

    // Tie from floor 1: up to 3 first, then back to 0.
    pulse(4'b1001);
    chk("tie_pend", 32'(obs()), 32'(o(2'd1, DIR_NONE, 1'b0, 1'b0, 4'b1001)));
    wait_doors(1'b1, 30, n);
    chk("tie_lat_up", n, 9);
    chk("tie_at3", 32'(obs()), 32'(o(2'd3, DIR_UP, 1'b1, 1'b1, 4'b0001)));
    wait_doors(1'b0, 10, n);
    chk("tie_close3", n, 3);
    chk("tie_rev", 32'(obs()), 32'(o(2'd3, DIR_DOWN, 1'b0, 1'b0, 4'b0001)));
    wait_doors(1'b1, 30, n);
    chk("tie_lat_dn", n, 12);
    chk("tie_at0", 32'(obs()), 32'(o(2'd0, DIR_DOWN, 1'b1, 1'b1, 4'b0000)));
    wait_doors(1'b0, 10, n);
    chk("tie_close0", n, 3);
    chk("tie_idle", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)));

    // Up to 3, calls for 0 and 2 arrive during the dwell.
    pulse(4'b1000);
    wait_doors(1'b1, 30, n);
    chk("rev_lat_up", n, 13);
    chk("rev_at3", 32'(obs()), 32'(o(2'd3, DIR_UP, 1'b1, 1'b1, 4'b0000)));
    pulse(4'b0101);
    chk("rev_inj", 32'(obs()), 32'(o(2'd3, DIR_UP, 1'b1, 1'b0, 4'b0101)));
    wait_doors(1'b0, 10, n);
    chk("rev_close3", n, 2);
    chk("rev_dir", 32'(obs()), 32'(o(2'd3, DIR_DOWN, 1'b0, 1'b0, 4'b0101)));
    wait_doors(1'b1, 30, n);
    chk("rev_lat2", n, 4);
    chk("rev_at2", 32'(obs()), 32'(o(2'd2, DIR_DOWN, 1'b1, 1'b1, 4'b0001)));
    wait_doors(1'b0, 10, n);
    chk("rev_close2", n, 3);
    chk("rev_keep", 32'(obs()), 32'(o(2'd2, DIR_DOWN, 1'b0, 1'b0, 4'b0001)));
    wait_doors(1'b1, 30, n);
    chk("rev_lat0", n, 8);
    chk("rev_at0", 32'(obs()), 32'(o(2'd0, DIR_DOWN, 1'b1, 1'b1, 4'b0000)));
    wait_doors(1'b0, 10, n);
    chk("rev_close0", n, 3);
    chk("rev_idle", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)));

    // Reset during the second travel cycle between floors 1 and 2.
    pulse(4'b1000);
    repeat (5) tick();
    chk("rst_at1", 32'(obs()), 32'(o(2'd1, DIR_UP, 1'b0, 1'b1, 4'b1000)));
    tick();
    chk("rst_mid", 32'(obs()), 32'(o(2'd1, DIR_UP, 1'b0, 1'b0, 4'b1000)));
    rst_n = 1'b0;
    tick();
    chk("rst_apply", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)));
    rst_n = 1'b1;
    repeat (6) tick();
    chk("rst_after", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b0, 1'b0, 4'b0000)));

`ifdef DOOR_HOLD_EN
    // Hold for 10 cycles, then a full dwell after release.
    pulse(4'b0001);
    tick();
    chk("hold_open", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b1, 1'b0, 4'b0000)));
    bus.boton_abrir = 1'b1;
    repeat (10) tick();
    chk("hold_kept", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b1, 1'b0, 4'b0000)));
    bus.boton_abrir = 1'b0;
    wait_doors(1'b0, 10, n);
    chk("hold_close", n, 3);
    // Re-call of the open floor restarts the dwell.
    pulse(4'b0001);
    tick();
    tick();
    pulse(4'b0001);
    chk("recall_set", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b1, 1'b0, 4'b0001)));
    tick();
    chk("recall_clr", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b1, 1'b0, 4'b0000)));
    wait_doors(1'b0, 10, n);
    chk("recall_close", n, 3);
    // Button alone opens the doors from idle.
    bus.boton_abrir = 1'b1;
    tick();
    bus.boton_abrir = 1'b0;
    chk("btn_idle", 32'(obs()), 32'(o(2'd0, DIR_NONE, 1'b1, 1'b0, 4'b0000)));
    wait_doors(1'b0, 10, n);
    chk("btn_close", n, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
